// File: rtl/nx_fifo_arb_pkg.sv
// Shared types and the round-robin search used by the FIFO write arbiter.
// rr_pick is sized for the largest supported requester count (16).
package nx_fifo_arb_pkg;

  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned MAX_IDW = 4;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr+1, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [MAX_IDW-1:0] ptr,
                                       input int unsigned        n);
    rr_pick_t    p;
    int unsigned j;
    p = '0;
    j = 0;
    for (int unsigned k = 1; k <= n; k++) begin
      j = (32'(ptr) + k) % n;
      if (!p.found && valid[j[MAX_IDW-1:0]]) begin
        p.found = 1'b1;
        p.idx   = j[MAX_IDW-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/nx_rr_pick.sv
// Combinational round-robin priority picker: valids plus last-winner pointer in,
// one-hot grant and encoded winner out.
module nx_rr_pick
  import nx_fifo_arb_pkg::*;
#(
  parameter int unsigned  NUM_REQ = 4,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDW-1:0]     i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_idx,
  output logic               o_found
);

  logic [MAX_REQ-1:0] w_valid;
  rr_pick_t           w_pick;

  always_comb begin
    w_valid                = '0;
    w_valid[NUM_REQ-1:0]   = i_valid;
    w_pick                 = rr_pick(w_valid, MAX_IDW'(i_ptr), NUM_REQ);
    o_found                = i_en & w_pick.found;
    o_idx                  = IDW'(w_pick.idx);
    o_grant                = '0;
    if (o_found) begin
      o_grant[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/nx_fifo_wr_arb.sv
// Round-robin write arbiter in front of an nx_fifo write port, with
// occupancy-aware backpressure and a drain/clear/done flush sequence.
module nx_fifo_wr_arb
  import nx_fifo_arb_pkg::*;
#(
  parameter int unsigned  NUM_REQ = 4,
  parameter int unsigned  WIDTH   = 4,
  parameter int unsigned  DEPTH   = 4,
  localparam int unsigned IDW     = $clog2(NUM_REQ),
  localparam int unsigned SW      = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     flush_req,
  output logic                     flush_done,
  input  logic [SW-1:0]            fifo_free_slots,
  input  logic                     fifo_overflow,
  output logic                     fifo_wen,
  output logic [IDW+WIDTH-1:0]     fifo_wdata,
  output logic                     fifo_clear,
  output logic [15:0]              wr_count,
  output logic                     ovf_err
);

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  logic [IDW-1:0]       r_ptr;
  logic                 r_wen;
  logic [IDW+WIDTH-1:0] r_wdata;
  logic                 r_clear;
  logic                 r_done;
  logic [15:0]          r_cnt;
  logic                 r_ovf;

  logic                 w_space;
  logic                 w_arb_en;
  logic [NUM_REQ-1:0]   w_grant;
  logic [IDW-1:0]       w_idx;
  logic                 w_xfer;
  logic [WIDTH-1:0]     w_payload;

  // The registered write in r_wen is not yet reflected in fifo_free_slots.
  assign w_space  = fifo_free_slots > SW'(r_wen);
  assign w_arb_en = (r_state == ARB) && w_space && !rst;

  nx_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_en    (w_arb_en),
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_found (w_xfer)
  );

  assign w_payload = req_data[w_idx*WIDTH +: WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB:   if (flush_req) w_state_nxt = DRAIN;
      // No grant is issued here, so the only outstanding write is the one
      // already in r_wen; it lands in the FIFO at the end of this cycle.
      DRAIN: if (!w_xfer)   w_state_nxt = CLEAR;
      CLEAR:                w_state_nxt = DONE;
      DONE:                 w_state_nxt = ARB;
      default:              w_state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB;
      r_ptr   <= IDW'(NUM_REQ - 1);
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_clear <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wen   <= w_xfer;
      r_clear <= (w_state_nxt == CLEAR);
      r_done  <= (w_state_nxt == DONE);
      r_ovf   <= r_ovf | fifo_overflow;
      if (w_xfer) begin
        r_wdata <= {w_idx, w_payload};
        r_ptr   <= w_idx;
        r_cnt   <= r_cnt + 16'd1;
      end
    end
  end

  assign req_ready  = w_grant;
  assign fifo_wen   = r_wen;
  assign fifo_wdata = r_wdata;
  assign fifo_clear = r_clear;
  assign flush_done = r_done;
  assign wr_count   = r_cnt;
  assign ovf_err    = r_ovf;

endmodule
